// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and defaults for the instruction-memory fetch arbiter
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

endpackage

// File: rtl/imem_fetch_arb_if.sv
// rtl/imem_fetch_arb_if.sv - one requester's read handshake into the fetch arbiter
interface imem_fetch_arb_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/imem_addr_xlate.sv
// rtl/imem_addr_xlate.sv - byte address to ROM word index with range/alignment check
module imem_addr_xlate
  import imem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          AW        = 11
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] index,
  output logic          err
);

  logic [31:0] off;

  // off wraps for addresses below BASE_ADDR, hence the explicit compare
  assign off   = addr - BASE_ADDR;
  assign index = off[AW+1:2];
  assign err   = (addr < BASE_ADDR) || (addr[1:0] != 2'b00) || ((off >> (AW + 2)) != 32'd0);

endmodule

// File: rtl/imem_fetch_arb.sv
// rtl/imem_fetch_arb.sv - arbitrates CPU fetch and debug read-back onto one ROM read port
module imem_fetch_arb
  import imem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          AW        = 11,
  parameter int          MEM_LAT   = 1,
  parameter int          CPU_PRIO  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_fetch_arb_if.slave cpu,
  imem_fetch_arb_if.slave dbg,
  output logic [AW-1:0] mem_a,
  output logic          mem_en,
  input  logic [31:0]   mem_q,
  output logic          busy
);

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  state_e        state;
  port_e         port_r;
  port_e         last_r;
  port_e         win;
  logic [1:0]    cnt;
  logic [AW-1:0] idx_r;
  logic          err_r;
  logic [AW-1:0] x_index;
  logic          x_err;
  logic [31:0]   win_addr;
  logic [31:0]   cap_data;
  logic          grant_ok;
  logic [31:0]   cpu_rdata_r;
  logic [31:0]   dbg_rdata_r;
  logic          cpu_rvalid_r;
  logic          dbg_rvalid_r;
  logic          cpu_err_r;
  logic          dbg_err_r;

  // CPU wins a tie under fixed priority or when debug held the last grant
  assign win = (cpu.req && (!dbg.req || CPU_PRIO != 0 || last_r == PORT_DBG)) ? PORT_CPU : PORT_DBG;
  assign win_addr = (win == PORT_CPU) ? cpu.addr : dbg.addr;
  assign grant_ok = rst_n && (state == IDLE) && (cpu.req || dbg.req);

  imem_addr_xlate #(
    .BASE_ADDR(BASE_ADDR),
    .AW       (AW)
  ) u_xlate (
    .addr (win_addr),
    .index(x_index),
    .err  (x_err)
  );

  assign cap_data = err_r ? 32'd0 : mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      port_r       <= PORT_CPU;
      last_r       <= PORT_DBG;
      cnt          <= 2'd0;
      idx_r        <= '0;
      err_r        <= 1'b0;
      cpu_rdata_r  <= 32'd0;
      dbg_rdata_r  <= 32'd0;
      cpu_rvalid_r <= 1'b0;
      dbg_rvalid_r <= 1'b0;
      cpu_err_r    <= 1'b0;
      dbg_err_r    <= 1'b0;
    end else begin
      cpu_rvalid_r <= 1'b0;
      dbg_rvalid_r <= 1'b0;
      cpu_err_r    <= 1'b0;
      dbg_err_r    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            port_r <= win;
            last_r <= win;
            idx_r  <= x_index;
            err_r  <= x_err;
            cnt    <= 2'd0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAT) begin
            if (port_r == PORT_CPU) begin
              cpu_rdata_r  <= cap_data;
              cpu_rvalid_r <= 1'b1;
              cpu_err_r    <= err_r;
            end else begin
              dbg_rdata_r  <= cap_data;
              dbg_rvalid_r <= 1'b1;
              dbg_err_r    <= err_r;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.gnt    = grant_ok && (win == PORT_CPU);
  assign dbg.gnt    = grant_ok && (win == PORT_DBG);
  assign cpu.rvalid = cpu_rvalid_r;
  assign dbg.rvalid = dbg_rvalid_r;
  assign cpu.rdata  = cpu_rdata_r;
  assign dbg.rdata  = dbg_rdata_r;
  assign cpu.err    = cpu_err_r;
  assign dbg.err    = dbg_err_r;
  assign mem_a      = idx_r;
  assign mem_en     = (state == WAIT) && !err_r;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_imem_fetch_arb.sv
// tb/tb_imem_fetch_arb.sv - randomized, model-checked bench over three latency/priority configs
module tb_imem_fetch_arb;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic [31:0] rom [2048];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %h expected %h (cycle %0d)", g, name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input int g, input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %b expected %b (cycle %0d)", g, name, act, exp, cyc);
    end
  endtask

  // legal iff word aligned and inside [BASE, BASE + 4*2048)
  function automatic void decode(input logic [31:0] a, output bit e, output int idx);
    longint unsigned la;
    longint unsigned lb;
    la = 64'(a);
    lb = 64'(BASE);
    if (la < lb || (a % 4) != 0 || la >= lb + 4 * 2048) begin
      e   = 1'b1;
      idx = 0;
    end else begin
      e   = 1'b0;
      idx = int'((la - lb) / 4);
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned s;
    s = $urandom_range(0, 7);
    case (s)
      0, 1, 2, 3: return BASE + 32'(4 * $urandom_range(0, 2047));
      4:          return ($urandom_range(0, 1) != 0) ? BASE + 32'h1FFC : BASE + 32'h2000;
      5:          return BASE - 32'd4;
      6:          return BASE + 32'(4 * $urandom_range(0, 2047)) + 32'($urandom_range(1, 3));
      default:    return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int ML   = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int PRIO = (g == 1) ? 1 : 0;

    imem_fetch_arb_if cpu_if ();
    imem_fetch_arb_if dbg_if ();
    logic [10:0] mem_a;
    logic        mem_en;
    logic [31:0] mem_q;
    logic        busy;

    assign cpu_if.req  = cpu_req;
    assign cpu_if.addr = cpu_addr;
    assign dbg_if.req  = dbg_req;
    assign dbg_if.addr = dbg_addr;

    imem_fetch_arb #(
      .BASE_ADDR(BASE),
      .AW       (11),
      .MEM_LAT  (ML),
      .CPU_PRIO (PRIO)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cpu   (cpu_if),
      .dbg   (dbg_if),
      .mem_a (mem_a),
      .mem_en(mem_en),
      .mem_q (mem_q),
      .busy  (busy)
    );

    // ROM model: data appears ML cycles after an enabled address, garbage otherwise
    bit [10:0] pa [4];
    bit        pe [4];
    always @(posedge clk) begin
      pa[0] <= mem_a;
      pe[0] <= mem_en;
      for (int k = 1; k < 4; k++) begin
        pa[k] <= pa[k-1];
        pe[k] <= pe[k-1];
      end
    end
    if (ML == 0) begin : comb_rom
      assign mem_q = mem_en ? rom[mem_a] : 32'hDEAD_BEEF;
    end else begin : pipe_rom
      assign mem_q = pe[ML-1] ? rom[pa[ML-1]] : 32'hDEAD_BEEF;
    end

    // transaction model: grant at cycle gc, memory busy gc+1..gc+ML+1, response at gc+ML+2
    int          free_at = 0;
    bit          pend = 1'b0;
    int          gc = 0;
    bit          pdbg = 1'b0;
    bit          perr = 1'b0;
    int          pidx = 0;
    logic [31:0] pdata = 32'd0;
    bit          last_dbg = 1'b1;

    always @(negedge clk) begin
      bit w_dbg;
      bit e;
      int ix;
      bit eg_cpu;
      bit eg_dbg;
      bit rv;
      bit men;
      bit bsy;
      eg_cpu = 1'b0;
      eg_dbg = 1'b0;
      if (!rst_n) begin
        pend     = 1'b0;
        free_at  = cyc + 1;
        last_dbg = 1'b1;
      end else if (cyc >= free_at && (cpu_req || dbg_req)) begin
        if (cpu_req && dbg_req) w_dbg = (PRIO != 0) ? 1'b0 : !last_dbg;
        else                    w_dbg = dbg_req;
        decode(w_dbg ? dbg_addr : cpu_addr, e, ix);
        pend     = 1'b1;
        gc       = cyc;
        pdbg     = w_dbg;
        perr     = e;
        pidx     = ix;
        pdata    = e ? 32'd0 : rom[ix];
        free_at  = cyc + ML + 3;
        last_dbg = w_dbg;
        eg_cpu   = !w_dbg;
        eg_dbg   = w_dbg;
      end
      rv  = pend && (cyc == gc + ML + 2);
      men = pend && !perr && (cyc > gc) && (cyc <= gc + ML + 1);
      bsy = pend && (cyc > gc) && (cyc <= gc + ML + 2);
      chk1(g, "cpu_gnt", cpu_if.gnt, eg_cpu);
      chk1(g, "dbg_gnt", dbg_if.gnt, eg_dbg);
      chk1(g, "cpu_rvalid", cpu_if.rvalid, rv && !pdbg);
      chk1(g, "dbg_rvalid", dbg_if.rvalid, rv && pdbg);
      chk1(g, "mem_en", mem_en, men);
      chk1(g, "busy", busy, bsy);
      if (rv || !rst_n) begin
        chk1(g, "cpu_err", cpu_if.err, rv && !pdbg && perr);
        chk1(g, "dbg_err", dbg_if.err, rv && pdbg && perr);
      end
      if (rv) chk(g, "rdata", pdbg ? dbg_if.rdata : cpu_if.rdata, pdata);
      if (men) chk(g, "mem_a", 32'(mem_a), 32'(pidx));
      if (!rst_n) chk(g, "rst_mem_a", 32'(mem_a), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // called at the negedge one cycle after a CPU grant at t0; reports first cpu rvalid per config
  task automatic wait_rv(input int t0, output int l0, output int l1, output int l2,
                         output logic [31:0] d0, output logic e0);
    l0 = -1;
    l1 = -1;
    l2 = -1;
    d0 = 32'hFFFF_FFFF;
    e0 = 1'bx;
    for (int i = 0; i < 10; i++) begin
      if (l0 < 0 && cfg[0].cpu_if.rvalid) begin
        l0 = cyc - t0;
        d0 = cfg[0].cpu_if.rdata;
        e0 = cfg[0].cpu_if.err;
      end
      if (l1 < 0 && cfg[1].cpu_if.rvalid) l1 = cyc - t0;
      if (l2 < 0 && cfg[2].cpu_if.rvalid) l2 = cyc - t0;
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    int          t0;
    int          l0;
    int          l1;
    int          l2;
    logic [31:0] d0;
    logic        e0;
    logic [31:0] bad [3];
    int          rc;
    int          dg;
    int          nrv;
    int          n0;
    int          n1;
    bit          o0 [4];
    bit          o1 [4];

    bad[0] = 32'h003F_FFFC;
    bad[1] = 32'h0040_0002;
    bad[2] = 32'h0040_2000;
    for (int i = 0; i < 2048; i++) rom[i] = $urandom;
    rom[2] = 32'h2001_0001;

    rst_n    = 1'b0;
    cpu_req  = 1'b0;
    dbg_req  = 1'b0;
    cpu_addr = 32'd0;
    dbg_addr = 32'd0;
    repeat (3) step();
    @(negedge clk);
    chk(0, "rst_cpu_rdata", cfg[0].cpu_if.rdata, 32'd0);
    chk(0, "rst_dbg_rdata", cfg[0].dbg_if.rdata, 32'd0);
    chk1(0, "rst_busy", cfg[0].busy, 1'b0);
    step();
    rst_n = 1'b1;

    // first fetch: word 2
    step();
    cpu_req  = 1'b1;
    cpu_addr = 32'h0040_0008;
    @(negedge clk);
    t0 = cyc;
    chk1(0, "first_gnt", cfg[0].cpu_if.gnt, 1'b1);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk(0, "first_mem_a", 32'(cfg[0].mem_a), 32'd2);
    chk1(0, "first_mem_en", cfg[0].mem_en, 1'b1);
    chk1(0, "first_busy", cfg[0].busy, 1'b1);
    wait_rv(t0, l0, l1, l2, d0, e0);
    chk(0, "lat_ml1", 32'(l0), 32'd3);
    chk(1, "lat_ml0", 32'(l1), 32'd2);
    chk(2, "lat_ml3", 32'(l2), 32'd5);
    chk(0, "first_rdata", d0, 32'h2001_0001);
    chk1(0, "first_err", e0, 1'b0);

    // rejected addresses
    for (int i = 0; i < 3; i++) begin
      step();
      cpu_req  = 1'b1;
      cpu_addr = bad[i];
      @(negedge clk);
      t0 = cyc;
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      wait_rv(t0, l0, l1, l2, d0, e0);
      chk(0, "bad_lat", 32'(l0), 32'd3);
      chk1(0, "bad_err", e0, 1'b1);
      chk(0, "bad_rdata", d0, 32'd0);
    end

    // last legal word
    step();
    cpu_req  = 1'b1;
    cpu_addr = 32'h0040_1FFC;
    @(negedge clk);
    t0 = cyc;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk(0, "last_mem_a", 32'(cfg[0].mem_a), 32'd2047);
    chk1(0, "last_mem_en", cfg[0].mem_en, 1'b1);
    wait_rv(t0, l0, l1, l2, d0, e0);
    chk1(0, "last_err", e0, 1'b0);
    chk(0, "last_rdata", d0, rom[2047]);

    // debug request arriving while the CPU read is in WAIT
    step();
    cpu_req  = 1'b1;
    cpu_addr = 32'h0040_0004;
    @(negedge clk);
    t0 = cyc;
    step();
    cpu_req  = 1'b0;
    dbg_req  = 1'b1;
    dbg_addr = 32'h0040_0010;
    rc = -1;
    dg = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rc < 0 && cfg[0].cpu_if.rvalid) rc = cyc;
      if (dg < 0 && cfg[0].dbg_if.gnt) dg = cyc;
      step();
    end
    dbg_req = 1'b0;
    chk(0, "cpu_then_dbg_rvalid", 32'(rc - t0), 32'd3);
    chk(0, "cpu_then_dbg_gnt", 32'(dg - rc), 32'd1);
    repeat (12) step();

    // both requesters held from reset
    rst_n    = 1'b0;
    cpu_req  = 1'b1;
    dbg_req  = 1'b1;
    cpu_addr = 32'h0040_0020;
    dbg_addr = 32'h0040_0030;
    step();
    step();
    rst_n = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cfg[0].cpu_if.gnt || cfg[0].dbg_if.gnt) begin
        if (n0 < 4) o0[n0] = cfg[0].dbg_if.gnt;
        n0++;
      end
      if (cfg[1].cpu_if.gnt || cfg[1].dbg_if.gnt) begin
        if (n1 < 4) o1[n1] = cfg[1].dbg_if.gnt;
        n1++;
      end
      step();
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    chk1(0, "tie_rr_count", n0 >= 4, 1'b1);
    chk1(1, "tie_prio_count", n1 >= 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk1(0, "tie_rr_order", o0[k], (k % 2) == 1);
      chk1(1, "tie_prio_order", o1[k], 1'b0);
    end
    repeat (10) step();

    // reset during WAIT drops the response
    cpu_req  = 1'b1;
    cpu_addr = 32'h0040_0040;
    @(negedge clk);
    t0 = cyc;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk1(0, "midrst_busy_before", cfg[0].busy, 1'b1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk1(0, "midrst_busy", cfg[0].busy, 1'b0);
    chk1(0, "midrst_mem_en", cfg[0].mem_en, 1'b0);
    step();
    rst_n = 1'b1;
    nrv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cfg[0].cpu_if.rvalid) nrv++;
      step();
    end
    chk(0, "midrst_no_rvalid", 32'(nrv), 32'd0);
    cpu_req  = 1'b1;
    cpu_addr = 32'h0040_0008;
    @(negedge clk);
    t0 = cyc;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    wait_rv(t0, l0, l1, l2, d0, e0);
    chk(0, "after_rst_lat", 32'(l0), 32'd3);
    chk(0, "after_rst_rdata", d0, 32'h2001_0001);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(0, 3) == 0) dbg_req = ~dbg_req;
      if ($urandom_range(0, 1) == 0) cpu_addr = rand_addr();
      if ($urandom_range(0, 1) == 0) dbg_addr = rand_addr();
      rst_n = ($urandom_range(0, 499) != 0);
    end
    step();
    rst_n   = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
